// File: rtl/deflect_port_alloc_pkg.sv
// Shared control-word field slices, direction indices and allocation helpers
// for the BLESS deflection port allocator.
package deflect_port_alloc_pkg;

  localparam int CONTROL_W = 13;
  localparam int RMATRIX_W = 4;
  localparam int NPORT     = 4;

  localparam logic [3:0] AGE_MAX = 4'hF;

  // Port and rmatrix bit positions share one encoding.
  localparam logic [1:0] DIR_N = 2'd0;
  localparam logic [1:0] DIR_S = 2'd1;
  localparam logic [1:0] DIR_E = 2'd2;
  localparam logic [1:0] DIR_W = 2'd3;

  typedef logic [CONTROL_W-1:0] control_t;

  function automatic logic valid_f(input control_t c);
    return c[12];
  endfunction

  function automatic logic [3:0] source_f(input control_t c);
    return c[11:8];
  endfunction

  function automatic logic [3:0] dest_f(input control_t c);
    return c[7:4];
  endfunction

  function automatic logic [3:0] age_f(input control_t c);
    return c[3:0];
  endfunction

  // A forwarded flit is live by definition, so the valid bit is forced.
  function automatic control_t age_inc(input control_t c);
    control_t r;
    r      = c;
    r[12]  = 1'b1;
    r[3:0] = (c[3:0] == AGE_MAX) ? AGE_MAX : c[3:0] + 4'd1;
    return r;
  endfunction

  // X productive bits first, then Y, then the lowest-index free port.
  function automatic logic [1:0] pick_port(input logic [NPORT-1:0] busy,
                                           input logic [RMATRIX_W-1:0] rm);
    logic [1:0] p;
    logic       hit;
    p   = 2'd0;
    hit = 1'b0;
    if      (rm[DIR_E] && !busy[DIR_E]) p = DIR_E;
    else if (rm[DIR_W] && !busy[DIR_W]) p = DIR_W;
    else if (rm[DIR_N] && !busy[DIR_N]) p = DIR_N;
    else if (rm[DIR_S] && !busy[DIR_S]) p = DIR_S;
    else begin
      for (int k = 0; k < NPORT; k++) begin
        if (!hit && !busy[k]) begin
          p   = 2'(k);
          hit = 1'b1;
        end
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/deflect_prio_rank.sv
// Combinational oldest-first rank of the four input flits (0 = highest);
// equal ages resolve to the lower input index.
module deflect_prio_rank
  import deflect_port_alloc_pkg::*;
(
  input  logic [NPORT-1:0][3:0] age,
  input  logic [NPORT-1:0]      vld,
  output logic [NPORT-1:0][1:0] rank
);

  always_comb begin
    rank = '0;
    for (int i = 0; i < NPORT; i++) begin
      for (int j = 0; j < NPORT; j++) begin
        if (j != i && vld[j] &&
            ((age[j] > age[i]) || ((age[j] == age[i]) && (j < i)))) begin
          rank[i] = rank[i] + 2'd1;
        end
      end
    end
  end

endmodule

// File: rtl/deflect_port_alloc.sv
// BLESS output-port allocator: one registered stage, oldest-first, losers deflect.
// Optional DEFLECT_STATS_EN adds a saturating count of non-productive placements.
module deflect_port_alloc
  import deflect_port_alloc_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int STARVE_LIM = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NPORT-1:0][CONTROL_W-1:0]  in_control,
  input  logic [NPORT-1:0][DATA_W-1:0]     in_data,
  input  logic [NPORT-1:0][RMATRIX_W-1:0]  in_rmatrix,
  input  logic [NPORT-1:0]                 in_resource_go,
  input  logic                             inj_valid,
  input  logic [CONTROL_W-1:0]             inj_control,
  input  logic [DATA_W-1:0]                inj_data,
  input  logic [RMATRIX_W-1:0]             inj_rmatrix,
  output logic                             inj_ready,
  output logic [NPORT-1:0][CONTROL_W-1:0]  out_control,
  output logic [NPORT-1:0][DATA_W-1:0]     out_data,
  output logic                             eject_valid,
  output logic [CONTROL_W-1:0]             eject_control,
  output logic [DATA_W-1:0]                eject_data,
  output logic                             inj_starve
`ifdef DEFLECT_STATS_EN
  ,
  output logic [15:0]                      deflect_count
`endif
);

  logic [NPORT-1:0]                vld, fwd, busy;
  logic [NPORT-1:0][3:0]           age;
  logic [NPORT-1:0][1:0]           rank;
  logic                            ej_any;
  logic [1:0]                      ej_idx, p;

  logic [NPORT-1:0][CONTROL_W-1:0] out_control_d, out_control_q;
  logic [NPORT-1:0][DATA_W-1:0]    out_data_d, out_data_q;
  logic                            eject_valid_d, eject_valid_q;
  logic [CONTROL_W-1:0]            eject_control_d, eject_control_q;
  logic [DATA_W-1:0]               eject_data_d, eject_data_q;
  logic [7:0]                      starve_cnt_d, starve_cnt_q;
  logic                            inj_starve_d, inj_starve_q;
`ifdef DEFLECT_STATS_EN
  logic [2:0]                      n_defl;
  logic [16:0]                     defl_sum;
  logic [15:0]                     deflect_count_d, deflect_count_q;
`endif

  always_comb begin
    for (int i = 0; i < NPORT; i++) begin
      vld[i] = valid_f(in_control[i]);
      age[i] = age_f(in_control[i]);
    end
  end

  deflect_prio_rank u_rank (
    .age  (age),
    .vld  (vld),
    .rank (rank)
  );

  always_comb begin
    ej_any = 1'b0;
    ej_idx = 2'd0;
    for (int r = 0; r < NPORT; r++) begin
      for (int i = 0; i < NPORT; i++) begin
        if (!ej_any && vld[i] && in_resource_go[i] && (rank[i] == 2'(r))) begin
          ej_any = 1'b1;
          ej_idx = 2'(i);
        end
      end
    end

    fwd = vld;
    if (ej_any) fwd[ej_idx] = 1'b0;
    inj_ready = !rst && inj_valid && !(&fwd);

    busy          = '0;
    p             = 2'd0;
    out_control_d = '0;
    out_data_d    = '0;
`ifdef DEFLECT_STATS_EN
    n_defl        = 3'd0;
`endif
    for (int r = 0; r < NPORT; r++) begin
      for (int i = 0; i < NPORT; i++) begin
        if (fwd[i] && (rank[i] == 2'(r))) begin
          p                = pick_port(busy, in_rmatrix[i]);
          busy[p]          = 1'b1;
          out_control_d[p] = age_inc(in_control[i]);
          out_data_d[p]    = in_data[i];
`ifdef DEFLECT_STATS_EN
          if (!in_rmatrix[i][p]) n_defl = n_defl + 3'd1;
`endif
        end
      end
    end

    // Injection always goes last; inj_ready guarantees a free port exists.
    if (inj_ready) begin
      p                = pick_port(busy, inj_rmatrix);
      busy[p]          = 1'b1;
      out_control_d[p] = age_inc(inj_control);
      out_data_d[p]    = inj_data;
`ifdef DEFLECT_STATS_EN
      if (!inj_rmatrix[p]) n_defl = n_defl + 3'd1;
`endif
    end

    eject_valid_d   = ej_any;
    eject_control_d = ej_any ? in_control[ej_idx] : '0;
    eject_data_d    = ej_any ? in_data[ej_idx]    : '0;

    if (inj_valid && !inj_ready)
      starve_cnt_d = (starve_cnt_q == 8'hFF) ? 8'hFF : starve_cnt_q + 8'd1;
    else
      starve_cnt_d = 8'd0;
    inj_starve_d = (32'(starve_cnt_d) >= STARVE_LIM);

`ifdef DEFLECT_STATS_EN
    defl_sum        = {1'b0, deflect_count_q} + 17'(n_defl);
    deflect_count_d = defl_sum[16] ? 16'hFFFF : defl_sum[15:0];
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_control_q   <= '0;
      out_data_q      <= '0;
      eject_valid_q   <= 1'b0;
      eject_control_q <= '0;
      eject_data_q    <= '0;
      starve_cnt_q    <= 8'd0;
      inj_starve_q    <= 1'b0;
`ifdef DEFLECT_STATS_EN
      deflect_count_q <= 16'd0;
`endif
    end else begin
      out_control_q   <= out_control_d;
      out_data_q      <= out_data_d;
      eject_valid_q   <= eject_valid_d;
      eject_control_q <= eject_control_d;
      eject_data_q    <= eject_data_d;
      starve_cnt_q    <= starve_cnt_d;
      inj_starve_q    <= inj_starve_d;
`ifdef DEFLECT_STATS_EN
      deflect_count_q <= deflect_count_d;
`endif
    end
  end

  assign out_control   = out_control_q;
  assign out_data      = out_data_q;
  assign eject_valid   = eject_valid_q;
  assign eject_control = eject_control_q;
  assign eject_data    = eject_data_q;
  assign inj_starve    = inj_starve_q;
`ifdef DEFLECT_STATS_EN
  assign deflect_count = deflect_count_q;
`endif

endmodule

// File: tb/tb_deflect_port_alloc.sv
// Directed bench for deflect_port_alloc with hand-computed expected outputs.
module tb_deflect_port_alloc;

  logic              clk;
  logic              rst;
  logic [3:0][12:0]  in_control;
  logic [3:0][31:0]  in_data;
  logic [3:0][3:0]   in_rmatrix;
  logic [3:0]        in_resource_go;
  logic              inj_valid;
  logic [12:0]       inj_control;
  logic [31:0]       inj_data;
  logic [3:0]        inj_rmatrix;
  logic              inj_ready;
  logic [3:0][12:0]  out_control;
  logic [3:0][31:0]  out_data;
  logic              eject_valid;
  logic [12:0]       eject_control;
  logic [31:0]       eject_data;
  logic              inj_starve;
`ifdef DEFLECT_STATS_EN
  logic [15:0]       deflect_count;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  logic [3:0][12:0] exp_ctl;

  deflect_port_alloc #(.DATA_W(32), .STARVE_LIM(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_control     (in_control),
    .in_data        (in_data),
    .in_rmatrix     (in_rmatrix),
    .in_resource_go (in_resource_go),
    .inj_valid      (inj_valid),
    .inj_control    (inj_control),
    .inj_data       (inj_data),
    .inj_rmatrix    (inj_rmatrix),
    .inj_ready      (inj_ready),
    .out_control    (out_control),
    .out_data       (out_data),
    .eject_valid    (eject_valid),
    .eject_control  (eject_control),
    .eject_data     (eject_data),
    .inj_starve     (inj_starve)
`ifdef DEFLECT_STATS_EN
    ,
    .deflect_count  (deflect_count)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [12:0] mk(input logic [3:0] src, input logic [3:0] dst,
                                     input logic [3:0] age);
    return {1'b1, src, dst, age};
  endfunction

  task automatic clear_inputs();
    in_control     = '0;
    in_data        = '0;
    in_rmatrix     = '0;
    in_resource_go = '0;
    inj_valid      = 1'b0;
    inj_control    = '0;
    inj_data       = '0;
    inj_rmatrix    = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    inj_valid = 1'b1;
    inj_control = mk(4'h1, 4'h2, 4'h0);
    #12;
    n_cmp++; if (out_control !== '0) begin n_bad++; $display("FAIL reset_ctl got %h want 0", out_control); end
    n_cmp++; if (out_data !== '0) begin n_bad++; $display("FAIL reset_data got %h want 0", out_data); end
    n_cmp++; if (eject_valid !== 1'b0) begin n_bad++; $display("FAIL reset_ej got %b want 0", eject_valid); end
    n_cmp++; if (inj_starve !== 1'b0) begin n_bad++; $display("FAIL reset_starve got %b want 0", inj_starve); end
    n_cmp++; if (inj_ready !== 1'b0) begin n_bad++; $display("FAIL reset_injrdy got %b want 0", inj_ready); end
    clear_inputs();
    step();
    rst = 1'b0;
    step();
    n_cmp++; if (out_control !== '0) begin n_bad++; $display("FAIL idle_ctl got %h want 0", out_control); end
  endtask

  task automatic test_single();
    in_control[0] = mk(4'h1, 4'h6, 4'd3);
    in_data[0]    = 32'hA000_0001;
    in_rmatrix[0] = 4'b0100;
    step();
    exp_ctl = '0;
    exp_ctl[2] = mk(4'h1, 4'h6, 4'd4);
    n_cmp++; if (out_control !== exp_ctl) begin n_bad++; $display("FAIL single_ctl got %h want %h", out_control, exp_ctl); end
    n_cmp++; if (out_data[2] !== 32'hA000_0001 || out_data[0] !== 32'h0) begin n_bad++; $display("FAIL single_data got %h want E=a0000001", out_data); end
    n_cmp++; if (eject_valid !== 1'b0) begin n_bad++; $display("FAIL single_ej got %b want 0", eject_valid); end
    clear_inputs();
  endtask

  task automatic test_deflect();
    in_control[0] = mk(4'h2, 4'h7, 4'd5);
    in_data[0]    = 32'hB000_0000;
    in_rmatrix[0] = 4'b0100;
    in_control[1] = mk(4'h3, 4'h8, 4'd2);
    in_data[1]    = 32'hB000_0001;
    in_rmatrix[1] = 4'b0100;
    step();
    exp_ctl = '0;
    exp_ctl[2] = mk(4'h2, 4'h7, 4'd6);
    exp_ctl[0] = mk(4'h3, 4'h8, 4'd3);
    n_cmp++; if (out_control !== exp_ctl) begin n_bad++; $display("FAIL deflect_ctl got %h want %h", out_control, exp_ctl); end
    n_cmp++; if (out_data[0] !== 32'hB000_0001) begin n_bad++; $display("FAIL deflect_data got %h want b0000001", out_data[0]); end
    clear_inputs();
  endtask

  task automatic test_eject();
    in_control[2] = mk(4'h4, 4'h5, 4'd7);
    in_data[2]    = 32'hC000_0002;
    in_control[3] = mk(4'h9, 4'h5, 4'd7);
    in_data[3]    = 32'hC000_0003;
    in_resource_go = 4'b1100;
    step();
    exp_ctl = '0;
    exp_ctl[0] = mk(4'h9, 4'h5, 4'd8);
    n_cmp++; if (eject_valid !== 1'b1) begin n_bad++; $display("FAIL eject_vld got %b want 1", eject_valid); end
    n_cmp++; if (eject_control !== mk(4'h4, 4'h5, 4'd7) || eject_data !== 32'hC000_0002) begin n_bad++; $display("FAIL eject_word got %h/%h want %h/c0000002", eject_control, eject_data, mk(4'h4, 4'h5, 4'd7)); end
    n_cmp++; if (out_control !== exp_ctl) begin n_bad++; $display("FAIL eject_defl got %h want %h", out_control, exp_ctl); end
    clear_inputs();
  endtask

  task automatic test_age_sat();
    in_control[3] = mk(4'hA, 4'hB, 4'hF);
    in_rmatrix[3] = 4'b0001;
    step();
    exp_ctl = '0;
    exp_ctl[0] = mk(4'hA, 4'hB, 4'hF);
    n_cmp++; if (out_control !== exp_ctl) begin n_bad++; $display("FAIL age_sat got %h want %h", out_control, exp_ctl); end
    clear_inputs();
  endtask

  task automatic test_x_first();
    in_control[0] = mk(4'h1, 4'h1, 4'd9);
    in_rmatrix[0] = 4'b1000;
    in_control[1] = mk(4'h2, 4'h2, 4'd1);
    in_rmatrix[1] = 4'b1001;
    step();
    exp_ctl = '0;
    exp_ctl[3] = mk(4'h1, 4'h1, 4'd10);
    exp_ctl[0] = mk(4'h2, 4'h2, 4'd2);
    n_cmp++; if (out_control !== exp_ctl) begin n_bad++; $display("FAIL x_then_y got %h want %h", out_control, exp_ctl); end
    clear_inputs();
  endtask

  task automatic test_injection();
    in_control[0] = mk(4'h3, 4'h3, 4'd2);
    in_rmatrix[0] = 4'b0100;
    inj_valid   = 1'b1;
    inj_control = mk(4'h5, 4'hC, 4'd0);
    inj_data    = 32'hD00D_0000;
    inj_rmatrix = 4'b0100;
    #1;
    n_cmp++; if (inj_ready !== 1'b1) begin n_bad++; $display("FAIL inj_ready got %b want 1", inj_ready); end
    step();
    exp_ctl = '0;
    exp_ctl[2] = mk(4'h3, 4'h3, 4'd3);
    exp_ctl[0] = mk(4'h5, 4'hC, 4'd1);
    n_cmp++; if (out_control !== exp_ctl) begin n_bad++; $display("FAIL inj_ctl got %h want %h", out_control, exp_ctl); end
    n_cmp++; if (out_data[0] !== 32'hD00D_0000) begin n_bad++; $display("FAIL inj_data got %h want d00d0000", out_data[0]); end
    clear_inputs();
  endtask

  task automatic test_starve();
    in_control[0] = mk(4'h0, 4'h0, 4'd4); in_rmatrix[0] = 4'b0001;
    in_control[1] = mk(4'h1, 4'h1, 4'd3); in_rmatrix[1] = 4'b0010;
    in_control[2] = mk(4'h2, 4'h2, 4'd2); in_rmatrix[2] = 4'b0100;
    in_control[3] = mk(4'h3, 4'h3, 4'd1); in_rmatrix[3] = 4'b1000;
    inj_valid   = 1'b1;
    inj_control = mk(4'h7, 4'h7, 4'd6);
    inj_data    = 32'hEEEE_0007;
    inj_rmatrix = 4'b0001;
    #1;
    n_cmp++; if (inj_ready !== 1'b0) begin n_bad++; $display("FAIL full_injrdy got %b want 0", inj_ready); end
    for (int k = 1; k <= 8; k++) begin
      step();
      if (k == 1) begin
        exp_ctl[0] = mk(4'h0, 4'h0, 4'd5);
        exp_ctl[1] = mk(4'h1, 4'h1, 4'd4);
        exp_ctl[2] = mk(4'h2, 4'h2, 4'd3);
        exp_ctl[3] = mk(4'h3, 4'h3, 4'd2);
        n_cmp++; if (out_control !== exp_ctl) begin n_bad++; $display("FAIL full_ctl got %h want %h", out_control, exp_ctl); end
      end
      if (k == 7) begin
        n_cmp++; if (inj_starve !== 1'b0) begin n_bad++; $display("FAIL starve_7 got %b want 0", inj_starve); end
      end
      if (k == 8) begin
        n_cmp++; if (inj_starve !== 1'b1) begin n_bad++; $display("FAIL starve_8 got %b want 1", inj_starve); end
      end
    end
    in_control[3] = '0;
    in_rmatrix[3] = '0;
    #1;
    n_cmp++; if (inj_ready !== 1'b1) begin n_bad++; $display("FAIL freed_injrdy got %b want 1", inj_ready); end
    step();
    n_cmp++; if (inj_starve !== 1'b0) begin n_bad++; $display("FAIL starve_clr got %b want 0", inj_starve); end
    n_cmp++; if (out_control[3] !== mk(4'h7, 4'h7, 4'd7)) begin n_bad++; $display("FAIL freed_inj got %h want %h", out_control[3], mk(4'h7, 4'h7, 4'd7)); end
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    in_control[0] = mk(4'h1, 4'h0, 4'd1);
    in_data[0]    = 32'h1234_5678;
    in_resource_go = 4'b0001;
    in_control[1] = mk(4'h2, 4'h4, 4'd2);
    in_rmatrix[1] = 4'b0010;
    step();
    n_cmp++; if (eject_valid !== 1'b1 || out_control[1] !== mk(4'h2, 4'h4, 4'd3)) begin n_bad++; $display("FAIL pre_rst got ej=%b S=%h want 1/%h", eject_valid, out_control[1], mk(4'h2, 4'h4, 4'd3)); end
    #2;
    rst = 1'b1;
    inj_valid = 1'b1;
    #1;
    n_cmp++; if (out_control !== '0 || out_data !== '0) begin n_bad++; $display("FAIL mid_rst_out got %h want 0", out_control); end
    n_cmp++; if (eject_valid !== 1'b0 || eject_control !== '0 || eject_data !== '0) begin n_bad++; $display("FAIL mid_rst_ej got %b/%h want 0", eject_valid, eject_control); end
    n_cmp++; if (inj_ready !== 1'b0) begin n_bad++; $display("FAIL mid_rst_injrdy got %b want 0", inj_ready); end
    clear_inputs();
    in_control[2] = mk(4'h6, 4'h9, 4'd3);
    in_rmatrix[2] = 4'b1000;
    rst = 1'b0;
    step();
    exp_ctl = '0;
    exp_ctl[3] = mk(4'h6, 4'h9, 4'd4);
    n_cmp++; if (out_control !== exp_ctl) begin n_bad++; $display("FAIL post_rst_ctl got %h want %h", out_control, exp_ctl); end
    n_cmp++; if (eject_valid !== 1'b0) begin n_bad++; $display("FAIL post_rst_ej got %b want 0", eject_valid); end
    clear_inputs();
  endtask

  initial begin
    exp_ctl = '0;
    test_reset();
    test_single();
    test_deflect();
    test_eject();
    test_age_sat();
    test_x_first();
    test_injection();
    test_starve();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
